// File: rtl/reed_pulse_emitter.sv
// reed_pulse_emitter: programmable reed-contact closure pulse train.
// Define REED_PULSE_BOUNCE_EN to add contact chatter at each closure.
module reed_pulse_emitter #(
  parameter int CNT_W          = 16,
  parameter int TIME_W         = 16,
  parameter int BOUNCE_TOGGLES = 4,
  parameter int BOUNCE_CYC     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  pulse_count,
  input  logic [TIME_W-1:0] high_cycles,
  input  logic [TIME_W-1:0] low_cycles,
  output logic              sensor_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pulses_sent
);

  typedef enum logic [1:0] {
    ST_IDLE, ST_HIGH, ST_LOW, ST_FIN
  } state_t;

  localparam logic [TIME_W-1:0] LP_ONE = TIME_W'(1);
  localparam logic [TIME_W-1:0] LP_TWO = TIME_W'(2);

  state_t            r_state, w_state_nx;
  logic [TIME_W-1:0] r_timer, w_timer_nx;
  logic [TIME_W-1:0] r_hlen, r_llen;
  logic [TIME_W-1:0] w_hlen_in, w_llen_in;
  logic [CNT_W-1:0]  r_count, r_sent, w_sent_nx;
  logic              r_out, w_out_nx;
  logic              r_busy, w_busy_nx;
  logic              r_done, w_done_nx;
  logic              w_load;
  logic              w_high_lvl;

  assign w_hlen_in = (high_cycles == '0) ? LP_ONE : high_cycles;
  assign w_llen_in = (low_cycles == '0) ? LP_ONE : low_cycles;

`ifdef REED_PULSE_BOUNCE_EN
  localparam logic [TIME_W-1:0] LP_BT      = TIME_W'(BOUNCE_TOGGLES);
  localparam logic [TIME_W-1:0] LP_BC_LAST = TIME_W'(BOUNCE_CYC - 1);

  logic [TIME_W-1:0] r_bcnt, r_blvl;
  logic [TIME_W-1:0] w_bcnt_nx, w_blvl_nx;

  // Next chatter position and the contact level it implies
  always_comb begin
    w_bcnt_nx = r_bcnt + LP_ONE;
    w_blvl_nx = r_blvl;
    if (r_bcnt >= LP_BC_LAST) begin
      w_bcnt_nx = '0;
      if (r_blvl < LP_BT) w_blvl_nx = r_blvl + LP_ONE;
    end
    w_high_lvl = (w_blvl_nx < LP_BT) ? ~w_blvl_nx[0] : 1'b1;
  end

  // Chatter position, restarted whenever a closure begins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bcnt <= '0;
      r_blvl <= '0;
    end else if (w_state_nx == ST_HIGH && r_state != ST_HIGH) begin
      r_bcnt <= '0;
      r_blvl <= '0;
    end else if (r_state == ST_HIGH) begin
      r_bcnt <= w_bcnt_nx;
      r_blvl <= w_blvl_nx;
    end
  end
`else
  assign w_high_lvl = 1'b1;
`endif

  // Next-state and next-output decode
  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_sent_nx  = r_sent;
    w_out_nx   = r_out;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_load     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load    = 1'b1;
          w_sent_nx = '0;
          if (pulse_count != '0) begin
            w_state_nx = ST_HIGH;
            w_out_nx   = 1'b1;
            w_busy_nx  = 1'b1;
            w_timer_nx = w_hlen_in;
          end else begin
            w_state_nx = ST_FIN;
            w_done_nx  = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (abort) begin
          w_state_nx = ST_FIN;
          w_out_nx   = 1'b0;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
        end else if (r_timer == LP_ONE) begin
          w_state_nx = ST_LOW;
          w_out_nx   = 1'b0;
          w_sent_nx  = r_sent + CNT_W'(1);
          w_timer_nx = r_llen;
        end else begin
          w_timer_nx = r_timer - LP_ONE;
          w_out_nx   = (r_timer == LP_TWO) ? 1'b1 : w_high_lvl;
        end
      end
      ST_LOW: begin
        if (abort) begin
          w_state_nx = ST_FIN;
          w_out_nx   = 1'b0;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
        end else if (r_timer == LP_ONE) begin
          if (r_sent == r_count) begin
            w_state_nx = ST_FIN;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
          end else begin
            w_state_nx = ST_HIGH;
            w_out_nx   = 1'b1;
            w_timer_nx = r_hlen;
          end
        end else begin
          w_timer_nx = r_timer - LP_ONE;
        end
      end
      ST_FIN: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State, timer, counters, latched config and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_hlen  <= '0;
      r_llen  <= '0;
      r_count <= '0;
      r_sent  <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_timer <= w_timer_nx;
      r_sent  <= w_sent_nx;
      r_out   <= w_out_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      if (w_load) begin
        r_count <= pulse_count;
        r_hlen  <= w_hlen_in;
        r_llen  <= w_llen_in;
      end
    end
  end

  assign sensor_out  = r_out;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pulses_sent = r_sent;

endmodule

// File: tb/tb_reed_pulse_emitter.sv
// tb_reed_pulse_emitter: directed and random trains against a
// cycle-indexed reference computed from phase arithmetic.
module tb_reed_pulse_emitter;

  localparam int BT = 4;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] pulse_count;
  logic [15:0] high_cycles;
  logic [15:0] low_cycles;
  logic        sensor_out;
  logic        busy;
  logic        done;
  logic [15:0] pulses_sent;

  int n_checks = 0;
  int n_err    = 0;

  reed_pulse_emitter #(
    .CNT_W(16), .TIME_W(16),
    .BOUNCE_TOGGLES(BT), .BOUNCE_CYC(BC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pulse_count(pulse_count), .high_cycles(high_cycles),
    .low_cycles(low_cycles), .sensor_out(sensor_out),
    .busy(busy), .done(done), .pulses_sent(pulses_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input bit e_out,
                           input bit e_busy, input bit e_done,
                           input int e_sent);
    check({tag, ".sensor"}, int'(sensor_out), int'(e_out));
    check({tag, ".busy"}, int'(busy), int'(e_busy));
    check({tag, ".done"}, int'(done), int'(e_done));
    check({tag, ".sent"}, int'(pulses_sent), e_sent);
  endtask

  // Contact level at offset r (0-based) within a closure of length h
  function automatic bit high_level(input int r, input int h);
`ifdef REED_PULSE_BOUNCE_EN
    if (r == h - 1) return 1'b1;
    if (r < BT * BC) return ((r / BC) % 2) == 0;
    return 1'b1;
`else
    return (r < h);
`endif
  endfunction

  // Called just after a negedge; leaves just after a negedge in IDLE.
  task automatic run_train(input string tag, input int cnt,
                           input int hi, input int lo,
                           input int ab_t, input bit noisy);
    int h, l, per, tot, stop, p, r, e_sent, last_sent;
    bit e_out, e_busy, e_done;
    h = (hi == 0) ? 1 : hi;
    l = (lo == 0) ? 1 : lo;
    per = h + l;
    tot = cnt * per;
    stop = (ab_t > 0 && ab_t <= tot) ? ab_t + 1 : tot + 1;
    last_sent = 0;
    start = 1'b1;
    pulse_count = 16'(cnt);
    high_cycles = 16'(hi);
    low_cycles = 16'(lo);
    for (int t = 1; t <= stop + 1; t++) begin
      @(negedge clk);
      if (t < stop) begin
        p = (t - 1) / per;
        r = (t - 1) % per;
        e_out = (r < h) ? high_level(r, h) : 1'b0;
        e_sent = p + ((r >= h) ? 1 : 0);
        e_busy = 1'b1;
        e_done = 1'b0;
        last_sent = e_sent;
      end else if (t == stop) begin
        e_out = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b1;
        e_sent = (stop == tot + 1) ? cnt : last_sent;
      end else begin
        e_out = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_sent = (stop == tot + 1) ? cnt : last_sent;
      end
      check_all($sformatf("%s.t%0d", tag, t), e_out, e_busy, e_done, e_sent);
      if (noisy) begin
        pulse_count = 16'($urandom);
        high_cycles = 16'($urandom);
        low_cycles = 16'($urandom);
      end
      start = noisy && (t <= stop) && ($urandom_range(0, 3) == 0);
      abort = (t == ab_t) || (t == stop && noisy);
      if (t == stop + 1) begin
        start = 1'b0;
        abort = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pulse_count = '0;
    high_cycles = '0;
    low_cycles = '0;
    repeat (3) @(negedge clk);
    check_all("reset", 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    @(negedge clk);
    check_all("idle", 1'b0, 1'b0, 1'b0, 0);

    run_train("c3h4l2", 3, 4, 2, 0, 1'b0);
    run_train("c0", 0, 7, 7, 0, 1'b0);
    run_train("c5h0l0", 5, 0, 0, 0, 1'b0);
    run_train("abort", 4, 3, 3, 14, 1'b1);
`ifdef REED_PULSE_BOUNCE_EN
    run_train("bounce", 1, 12, 2, 0, 1'b0);
    run_train("bshort", 2, 5, 1, 0, 1'b0);
`endif

    // Reset mid-train in the low phase of a two-closure train
    start = 1'b1;
    pulse_count = 16'd2;
    high_cycles = 16'd3;
    low_cycles = 16'd3;
    @(negedge clk);
    start = 1'b0;
    check_all("rst.t1", 1'b1, 1'b1, 1'b0, 0);
    repeat (4) @(negedge clk);
    check_all("rst.t5", 1'b0, 1'b1, 1'b0, 1);
    reset = 1'b1;
    @(negedge clk);
    check_all("rst.hit", 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    run_train("rst.after", 1, 1, 1, 0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      int c, hh, ll, ab;
      c = $urandom_range(0, 6);
      hh = $urandom_range(0, 6);
      ll = $urandom_range(0, 6);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 50) : 0;
      run_train($sformatf("rnd%0d", k), c, hh, ll, ab, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/reed_pulse_emitter.md
Name: reed_pulse_emitter

Overview:
- Generates a reed-switch-compatible closure pulse train on a single output.
- Used to drive reed-sensor inputs on-board, as a loopback stimulus or as a flow-meter/anemometer emulator, so sensor-detect logic can be exercised without a magnet.
- Host logic requests N closures with programmable closed/open times. The block reports progress and completion through a start/busy/done handshake.

Parameters:
- CNT_W, 16, width of pulse_count and pulses_sent.
- TIME_W, 16, width of high_cycles and low_cycles (phase lengths in clk cycles).
- BOUNCE_TOGGLES, 4, number of chatter levels at the start of each closure. Used only with the optional feature.
- BOUNCE_CYC, 2, clk cycles each chatter level is held. Used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- abort  input  1  terminate an active train.
- pulse_count  input  CNT_W  closures to emit; latched on accepted start.
- high_cycles  input  TIME_W  closed (sensor_out=1) phase length; latched on accepted start.
- low_cycles  input  TIME_W  open (sensor_out=0) phase length; latched on accepted start.
- sensor_out  output  1  emulated reed contact; 1 = closed.
- busy  output  1  high while a train is in progress.
- done  output  1  one-cycle completion/abort pulse.
- pulses_sent  output  CNT_W  completed closures in the current or last train.

Behaviour:
- All outputs are registered.
- Reset: state=IDLE; sensor_out=0, busy=0, done=0, pulses_sent=0; latched config cleared.
- Reset takes effect at the next clk edge from any state, mid-train included. The output goes low immediately and no done is generated.
- FSM states: IDLE, HIGH_PH, LOW_PH, FIN.
- IDLE, start=1, pulse_count!=0:
  - Latch the config and clear pulses_sent.
  - At that same edge: sensor_out=1, busy=1, go to HIGH_PH.
  - Phase timer loaded with H = max(high_cycles,1).
- IDLE, start=1, pulse_count=0: go to FIN. sensor_out stays 0, busy stays 0, pulses_sent is cleared to 0.
- HIGH_PH:
  - sensor_out=1 for exactly H cycles.
  - Then sensor_out=0, pulses_sent+1, go to LOW_PH with L = max(low_cycles,1).
- LOW_PH:
  - sensor_out=0 for exactly L cycles.
  - Then, if pulses_sent==latched count: go to FIN, busy=0.
  - Otherwise: go to HIGH_PH, sensor_out=1.
- FIN: done=1 for exactly one cycle, then IDLE.
- Timing from an accepted start to done: the train occupies count*(H+L) cycles from the start edge, and done asserts in the following cycle.
- Inputs during a train:
  - start is ignored outside IDLE, including in FIN.
  - Config inputs are don't-care after latch; changes have no effect mid-train.
- abort (HIGH_PH or LOW_PH): next edge sensor_out=0, busy=0, go to FIN (done pulse). pulses_sent holds its value; a closure in progress is not counted. abort in IDLE/FIN is ignored.
- abort has priority over phase expiry in the same cycle.
- Counter width: pulses_sent never wraps, because count is capped at 2^CNT_W-1 by width. Phase timers are TIME_W wide, so the maximum phase is 2^TIME_W-1 cycles.

Optional Feature:
- Macro: REED_PULSE_BOUNCE_EN.
- Defined:
  - Each HIGH_PH begins with contact chatter: sensor_out alternates 1,0,1,0,...
  - There are BOUNCE_TOGGLES levels, each held BOUNCE_CYC cycles, then stable 1 for the rest of the phase.
  - Chatter cycles count inside H.
  - If BOUNCE_TOGGLES*BOUNCE_CYC >= H, chatter is truncated so the final cycle of HIGH_PH is 1.
  - LOW_PH is clean.
  - pulses_sent counts one closure per HIGH_PH regardless of chatter.
- Not defined: clean pulses as in Behaviour; BOUNCE_* parameters unused, no chatter logic synthesized.

Test Plan:
- Reset, then start with count=3, high=4, low=2 -> sensor_out pattern 1111 00 1111 00 1111 00. busy high 18 cycles. pulses_sent steps 1,2,3 at each falling edge. done one cycle at cycle 19. busy=0 with done.
- Start with count=0 -> done pulses one cycle later. sensor_out=0, busy=0, pulses_sent=0 throughout.
- Start with count=5, high=0, low=0 -> treated as 1/1: sensor_out toggles 1,0 five times. pulses_sent=5. done after 10 cycles.
- Start with count=4, high=3, low=3; assert abort in the 2nd cycle of the 3rd high phase -> sensor_out=0 next edge, pulses_sent=2, done one cycle, busy=0. start pulsed mid-train earlier has no effect.
- Reset asserted in LOW_PH of a count=2 train -> next edge all outputs 0 and state IDLE, no done. A new start is accepted the cycle after reset deasserts.
- With REED_PULSE_BOUNCE_EN, count=1, high=12, low=2, BOUNCE_TOGGLES=4, BOUNCE_CYC=2 -> sensor_out 11 00 11 00 1111 00. pulses_sent=1 and done follows.
